neuron_sequencer: RTL

- Control stage directly upstream of the processing element.
- Loads one neuron's weight vector into the PE's SRAM bank through the demux, streams the matching input vector, and sequences the accumulation.
- Captures the quantized ReLU result from the PE and hands it downstream over a valid/ready port.
- Banks alternate every neuron, so the bank just computed is never overwritten in the next neuron's load.

---
 rtl/neuron_seq_pkg.sv | 23 ++
 rtl/neuron_sequencer_seq_counter.sv | 45 ++++
 rtl/neuron_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_seq_pkg.sv
// ---------------------------------------------------------------------------
// neuron_seq_pkg
// Shared types and default sizes for the neuron sequencer.
//   seq_state_e         : sequencer FSM states
//   FAN_IN_DEFAULT      : products accumulated per neuron
//   NUM_ADDRESS_DEFAULT : depth of each PE SRAM bank
//   ADDR_W_DEFAULT      : SRAM address width for the default depth
// ---------------------------------------------------------------------------
package neuron_seq_pkg;

    localparam int FAN_IN_DEFAULT      = 16;
    localparam int NUM_ADDRESS_DEFAULT = 512;
    localparam int ADDR_W_DEFAULT      = $clog2(NUM_ADDRESS_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_OUTPUT  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/neuron_sequencer_seq_counter.sv
// ---------------------------------------------------------------------------
// seq_counter
// Up-counter with synchronous clear and a terminal-count flag.
//   clk     : clock, rising edge
//   reset   : synchronous active-low reset, counter to 0
//   i_clr   : load-clear (has priority over i_en)
//   i_en    : increment by one
//   o_cnt   : current count
//   o_tc    : high when o_cnt equals MAX
// The counter itself never saturates; the caller gates i_en with o_tc
// or clears on o_tc, depending on whether it wants to stop or restart.
// ---------------------------------------------------------------------------
module seq_counter
    import neuron_seq_pkg::*;
#(
    parameter int           W   = ADDR_W_DEFAULT,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Count register: clear, increment or hold
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= {W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {W{1'b0}};
        end else if (i_en) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == MAX);

endmodule

// File: rtl/neuron_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_sequencer
// Loads one neuron's weights into a PE SRAM bank, streams the matching
// input vector through the PE, captures the PE result and offers it on a
// valid/ready port. Banks alternate per neuron.
// Optional feature macro: NEURON_SEQ_PERF_CNT_EN adds perf_cycles, the
// number of cycles (stalls included) spent in COMPUTE for the last neuron.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   w_valid/w_ready/w_data     : weight stream in
//   x_valid/x_ready/x_data     : input-activation stream in
//   pe_weight, pe_input_data   : data to the PE
//   pe_demux_select            : bank being written
//   pe_mux_select              : bank being read
//   pe_write_enable/read_enable: SRAM strobes
//   pe_addr                    : SRAM address shared by both banks
//   pe_reset                   : active-low clear of PE registers
//   pe_out                     : PE quantized result
//   y_valid/y_ready/y_data     : result stream out
//   busy                       : high whenever not IDLE
//   perf_cycles (optional)     : COMPUTE cycle count, saturating
// ---------------------------------------------------------------------------
module neuron_sequencer
    import neuron_seq_pkg::*;
#(
    parameter int WEIGHT_BIT  = 32,
    parameter int FAN_IN      = FAN_IN_DEFAULT,
    parameter int NUM_ADDRESS = NUM_ADDRESS_DEFAULT,
    parameter int ADDR_W      = $clog2(NUM_ADDRESS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [WEIGHT_BIT-1:0] w_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [WEIGHT_BIT-1:0] x_data,
    output logic [WEIGHT_BIT-1:0] pe_weight,
    output logic [WEIGHT_BIT-1:0] pe_input_data,
    output logic                  pe_demux_select,
    output logic                  pe_mux_select,
    output logic                  pe_write_enable,
    output logic                  pe_read_enable,
    output logic [ADDR_W-1:0]     pe_addr,
    output logic                  pe_reset,
    input  logic [WEIGHT_BIT-1:0] pe_out,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [WEIGHT_BIT-1:0] y_data,
    output logic                  busy
`ifdef NEURON_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    seq_state_e            r_state;
    seq_state_e            w_next_state;
    logic                  r_bank;
    logic                  r_y_valid;
    logic [WEIGHT_BIT-1:0] r_y_data;

    logic [ADDR_W-1:0]     w_cnt;
    logic                  w_cnt_tc;
    logic                  w_cnt_clr;
    logic                  w_cnt_en;

    logic                  w_wr_rdy;
    logic                  w_x_rdy;
    logic                  w_we;
    logic                  w_re;
    logic                  w_pe_rst_n;
    logic [ADDR_W-1:0]     w_addr;
    logic [WEIGHT_BIT-1:0] w_weight;
    logic [WEIGHT_BIT-1:0] w_input;
    logic                  w_capture;
    logic                  w_handshake;

    // Beat counter: addresses the SRAM in both LOAD and COMPUTE
    seq_counter #(
        .W   (ADDR_W),
        .MAX (ADDR_W'(FAN_IN - 1))
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_cnt (w_cnt),
        .o_tc  (w_cnt_tc)
    );

    // Next-state and per-cycle PE control
    always_comb begin
        w_next_state = r_state;
        w_wr_rdy     = 1'b0;
        w_x_rdy      = 1'b0;
        w_we         = 1'b0;
        w_re         = 1'b0;
        w_pe_rst_n   = 1'b1;
        w_addr       = {ADDR_W{1'b0}};
        w_weight     = {WEIGHT_BIT{1'b0}};
        w_input      = {WEIGHT_BIT{1'b0}};
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        w_capture    = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            // IDLE accepts the first weight at address 0 (cnt is 0 here);
            // the PE is held clear until the input stream starts.
            ST_IDLE, ST_LOAD: begin
                w_wr_rdy   = 1'b1;
                w_pe_rst_n = 1'b0;
                w_addr     = w_cnt;
                if (w_valid) begin
                    w_we     = 1'b1;
                    w_weight = w_data;
                    if (w_cnt_tc) begin
                        w_cnt_clr    = 1'b1;
                        w_next_state = ST_COMPUTE;
                    end else begin
                        w_cnt_en     = 1'b1;
                        w_next_state = ST_LOAD;
                    end
                end else begin
                    w_next_state = r_state;
                end
            end
            // Stall cycles feed a zero input so the PE adds a zero product.
            ST_COMPUTE: begin
                w_x_rdy = 1'b1;
                w_re    = 1'b1;
                w_addr  = w_cnt;
                if (x_valid) begin
                    w_input = x_data;
                    if (w_cnt_tc) begin
                        w_cnt_clr    = 1'b1;
                        w_next_state = ST_DRAIN;
                    end else begin
                        w_cnt_en     = 1'b1;
                        w_next_state = ST_COMPUTE;
                    end
                end else begin
                    w_next_state = ST_COMPUTE;
                end
            end
            // Last product has reached the adder; pe_out is final now.
            ST_DRAIN: begin
                w_capture    = 1'b1;
                w_next_state = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (y_ready) begin
                    w_handshake  = 1'b1;
                    w_pe_rst_n   = 1'b0;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_OUTPUT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, bank select and captured result
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bank    <= 1'b0;
            r_y_valid <= 1'b0;
            r_y_data  <= {WEIGHT_BIT{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_y_data  <= pe_out;
                r_y_valid <= 1'b1;
            end else if (w_handshake) begin
                r_y_valid <= 1'b0;
                r_bank    <= ~r_bank;
            end else begin
                r_y_valid <= r_y_valid;
            end
        end
    end

    // During reset no strobe or ready may escape and the PE is cleared.
    assign w_ready         = reset & w_wr_rdy;
    assign x_ready         = reset & w_x_rdy;
    assign pe_write_enable = reset & w_we;
    assign pe_read_enable  = reset & w_re;
    assign pe_reset        = reset & w_pe_rst_n;
    assign pe_weight       = w_weight;
    assign pe_input_data   = w_input;
    assign pe_addr         = w_addr;
    assign pe_demux_select = r_bank;
    assign pe_mux_select   = r_bank;
    assign y_valid         = r_y_valid;
    assign y_data          = r_y_data;
    assign busy            = (r_state != ST_IDLE);

`ifdef NEURON_SEQ_PERF_CNT_EN
    logic        w_perf_clr;
    logic        w_perf_en;
    logic        w_perf_tc;

    // Cleared on COMPUTE entry, counts every COMPUTE cycle, sticks at all-ones
    assign w_perf_clr = (r_state != ST_COMPUTE) && (w_next_state == ST_COMPUTE);
    assign w_perf_en  = (r_state == ST_COMPUTE) && !w_perf_tc;

    seq_counter #(
        .W   (32),
        .MAX ({32{1'b1}})
    ) u_perf (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_perf_clr),
        .i_en  (w_perf_en),
        .o_cnt (perf_cycles),
        .o_tc  (w_perf_tc)
    );
`endif

endmodule
